// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration handshake: requester-side request vector, arbiter-side grant and select.
interface bus_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned SEL_WIDTH = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [SEL_WIDTH-1:0] sel;
    logic                 bus_valid;

    modport master (output req, input gnt, input sel, input bus_valid);
    modport slave  (input req, output gnt, output sel, output bus_valid);
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a one-cycle turnaround between owners and a bounded hold time.
module bus_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned SEL_WIDTH = $clog2(NUM_REQ),
    parameter int unsigned MAX_HOLD  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.slave  bus
);
    localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] last_q, last_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic                 bus_valid_q, bus_valid_d;
    logic [SEL_WIDTH-1:0] base, idx, winner;
    logic                 found, any_req, others_req;

    assign any_req    = |bus.req;
    assign others_req = |(bus.req & ~gnt_q);
    // sel_q still names the previous owner during the turnaround cycle
    assign base       = (state_q == StTurn) ? sel_q : last_q;

    always_comb begin
        winner = base;
        found  = 1'b0;
        idx    = base;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = base + SEL_WIDTH'(i);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (any_req) state_d = StGrant;
            StGrant: begin
                if (!bus.req[sel_q] || (hold_q == HoldMax && others_req)) begin
                    state_d = StTurn;
                end
            end
            StTurn:  state_d = any_req ? StGrant : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_d       = '0;
        sel_d       = sel_q;
        last_d      = last_q;
        hold_d      = hold_q;
        bus_valid_d = (state_d == StGrant);
        if (state_q == StTurn) begin
            last_d = sel_q;
        end
        if (state_d == StGrant) begin
            if (state_q != StGrant) begin
                sel_d  = winner;
                hold_d = '0;
            end else if (hold_q != HoldMax) begin
                hold_d = hold_q + HoldW'(1);
            end
            gnt_d = NUM_REQ'(1) << sel_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            sel_q       <= '0;
            last_q      <= '1;
            hold_q      <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.bus_valid = bus_valid_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (MAX_HOLD 8 and 1) checked against a cycle-level ownership model.
module tb_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_REQ(4)) bus8 ();
    bus_arbiter_if #(.NUM_REQ(4)) bus1 ();
    assign bus8.req = req;
    assign bus1.req = req;

    bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Model: who owns the bus, for how many cycles, and whose turn it was last
    int m_owner[2];
    int m_held[2];
    int m_last[2];
    int m_sel[2];
    int maxh[2] = '{8, 1};

    function automatic int pick(int last, logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt(int i);
        return (m_owner[i] >= 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1;
            m_held[i]  = 0;
            m_last[i]  = 3;
            m_sel[i]   = 0;
        end
    endtask

    task automatic model_edge(logic [3:0] r);
        for (int i = 0; i < 2; i++) begin
            if (m_owner[i] >= 0) begin
                logic others;
                others = (r & ~(4'b0001 << m_owner[i])) != 4'b0000;
                if (!r[m_owner[i]] || (m_held[i] >= maxh[i] && others)) begin
                    m_last[i]  = m_owner[i];
                    m_owner[i] = -1;
                end else begin
                    m_held[i]++;
                end
            end else if (r != 4'b0000) begin
                m_owner[i] = pick(m_last[i], r);
                m_sel[i]   = m_owner[i];
                m_held[i]  = 1;
            end
        end
    endtask

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("gnt_h8", 32'(bus8.gnt), 32'(exp_gnt(0)));
        check_eq("sel_h8", 32'(bus8.sel), 32'(m_sel[0]));
        check_eq("valid_h8", 32'(bus8.bus_valid), 32'(m_owner[0] >= 0));
        check_eq("gnt_h1", 32'(bus1.gnt), 32'(exp_gnt(1)));
        check_eq("sel_h1", 32'(bus1.sel), 32'(m_sel[1]));
        check_eq("valid_h1", 32'(bus1.bus_valid), 32'(m_owner[1] >= 0));
    endtask

    task automatic step(logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] r;
        req = 4'b1111;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_eq("rst_gnt", 32'(bus8.gnt), 32'd0);
        check_eq("rst_sel", 32'(bus8.sel), 32'd0);
        check_eq("rst_valid", 32'(bus8.bus_valid), 32'd0);
        rst_n = 1'b1;
        step(4'b1111);
        check_eq("first_gnt", 32'(bus8.gnt), 32'h1);
        repeat (3) step(4'b0000);

        repeat (3) step(4'b0100);
        repeat (3) step(4'b0000);

        // Rotation: the current owner drops its request after one granted cycle
        for (int c = 0; c < 14; c++) begin
            r = 4'b1111;
            if (m_owner[0] >= 0) r[m_owner[0]] = 1'b0;
            step(r);
        end
        repeat (2) step(4'b0000);

        repeat (20) step(4'b0011);
        repeat (2) step(4'b0000);

        repeat (20) step(4'b1000);
        check_eq("uncontended", 32'(bus8.gnt), 32'h8);
        repeat (2) step(4'b0000);

        // Asynchronous reset while requester 1 owns the bus
        repeat (2) step(4'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_gnt", 32'(bus8.gnt), 32'd0);
        check_eq("async_valid", 32'(bus8.bus_valid), 32'd0);
        check_eq("async_gnt_h1", 32'(bus1.gnt), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        step(4'b1111);
        check_eq("post_rst_gnt", 32'(bus8.gnt), 32'h1);

        r = 4'b0000;
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            step(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Round-robin arbiter that decides which of `NUM_REQ` requesters owns the shared datapath bus.
- Drives the select input of the `mux` tree that steers the bus; its `sel` output connects directly to that tree's `S`.
- Inserts a one-cycle turnaround between owners so two tran-gated sources never drive the bus in the same cycle.
- Bounds ownership with a hold-cycle limit so no requester can starve the others.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters; must be a power of two, ≥ 2.
- `SEL_WIDTH`, default `$clog2(NUM_REQ)`: width of the encoded select.
- `MAX_HOLD`, default 8: maximum `GRANT` cycles before forced handover when others are waiting; must be ≥ 1.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req` input `NUM_REQ`: level request per requester; held high while the requester wants or holds the bus.
- `gnt` output `NUM_REQ`: one-hot grant, registered; all-zero when no owner.
- `sel` output `SEL_WIDTH`: encoded index of the current or last owner, registered.
- `bus_valid` output 1: high exactly when `gnt` is non-zero.

## Operation

Reset values (asynchronous, while `rst_n` = 0):
- state = `IDLE`, `gnt` = 0, `sel` = 0, `bus_valid` = 0.
- hold counter = 0.
- last-owner pointer = `NUM_REQ`-1, so requester 0 has first priority.

Arbitration rule:
- Winner = first requester with `req` high, searching upward from last-owner+1 modulo `NUM_REQ` (wrap-around).

States and transitions:
- `IDLE`:
  - If `req` is non-zero: go to `GRANT` with the winner.
  - Else stay.
- `GRANT`:
  - `gnt[owner]` = 1, `sel` = owner, `bus_valid` = 1.
  - Hold counter increments each cycle and saturates at `MAX_HOLD`-1.
  - If `req[owner]` = 0: go to `TURN`.
  - Else if the counter = `MAX_HOLD`-1 and any other `req` bit is high: go to `TURN` (forced handover).
  - Else stay; the counter saturates and ownership continues while no other requester is pending.
- `TURN`:
  - `gnt` = 0, `bus_valid` = 0, `sel` holds the previous owner.
  - Last-owner pointer updates to the previous owner.
  - Lasts exactly 1 cycle.
  - If `req` is non-zero: go directly to `GRANT` with the winner, which may be the previous owner if it is the only one still requesting.
  - Else go to `IDLE`.
- Hold counter clears on every entry to `GRANT`.

Invariants:
- `gnt` is always zero or one-hot.
- `sel` changes only on entry to `GRANT`.
- `bus_valid` equals OR of `gnt`.

Boundary cases:
- Simultaneous requests: the round-robin pointer decides the winner.
- Owner drops `req` on the same edge another raises it: `TURN`, then `GRANT` to the new winner.
- `MAX_HOLD` = 1: every `GRANT` lasts 1 cycle when contended.
- Reset asserted mid-`GRANT`: `gnt` clears immediately, without waiting for `clk`.
- Reset release: first arbitration happens on the first rising edge with `rst_n` = 1.

## Timing

- `req` rise in `IDLE` → `gnt`/`bus_valid` high after 1 rising edge (latency 1).
- Owner `req` fall → `gnt` low after 1 edge; next owner granted after 2 edges from the fall.
- Bus-idle gap between consecutive owners: always exactly 1 cycle.
- Forced handover:
  - Owner keeps `gnt` for exactly `MAX_HOLD` cycles.
  - Then 1 `TURN` cycle.
  - Then the next winner is granted.
- All outputs come from registers; no combinational path from `req` to `gnt`, `sel` or `bus_valid`.

## Test plan

- **Reset:**
  - Stimulus: hold `rst_n` = 0 with `req` = 4'b1111, then release.
  - Required: `gnt` = 0, `sel` = 0 during reset; after 1 edge `gnt` = 4'b0001, `sel` = 0.
- **Single owner release:**
  - Stimulus: `req` = 4'b0100 for 3 cycles, then 0.
  - Required: `gnt` = 4'b0100 for 3 cycles, `sel` = 2; then `gnt` = 0 in `TURN`; then `IDLE`.
- **Round-robin rotation:**
  - Stimulus: `req` = 4'b1111, each owner drops its `req` after 1 granted cycle and re-raises it.
  - Required: grant order 0, 1, 2, 3, 0, with one zero-`gnt` cycle between each grant.
- **Forced handover:**
  - Stimulus: `MAX_HOLD` = 8, `req` = 4'b0011 held high continuously.
  - Required: `gnt` = 4'b0001 for 8 cycles, 1 zero cycle, then `gnt` = 4'b0010 for 8 cycles.
- **Uncontended hold:**
  - Stimulus: `req` = 4'b1000 held high for 20 cycles.
  - Required: `gnt` = 4'b1000 for all 20 cycles, no `TURN` inserted.
- **Reset mid-grant:**
  - Stimulus: assert `rst_n` = 0 asynchronously, between edges, while `gnt` = 4'b0010.
  - Required: `gnt` = 0 and `bus_valid` = 0 immediately; after release, requester 0 has priority again.
